// File: rtl/vend_sequencer.sv
// vend_sequencer: coin accumulation, price compare, dispense handshake with
// timeout, and change/refund pulse train for the soda dispenser.
module vend_sequencer #(
  parameter int WIDTH    = 8,
  parameter int CHG_UNIT = 5,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] s,
  input  logic             cancel,
  input  logic             disp_done,
  output logic             d,
  output logic             chg,
  output logic [WIDTH-1:0] tot,
  output logic             busy,
  output logic             fault
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] UNIT  = WIDTH'(CHG_UNIT);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ADD    = 3'd2;
  localparam logic [2:0] S_DISP   = 3'd3;
  localparam logic [2:0] S_CHANGE = 3'd4;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_tot;
  logic [WIDTH-1:0] r_ahold;
  logic [TW-1:0]    r_timer;
  logic             r_cq;

  logic             w_coin;
  logic [WIDTH:0]   w_sum;
  logic             w_tmo;
  logic             w_price_met;
  logic             w_can_pay;

  assign w_coin      = c & ~r_cq;
  // One extra bit catches the carry so the add can saturate instead of wrap.
  assign w_sum       = {1'b0, r_tot} + {1'b0, r_ahold};
  assign w_tmo       = (r_state == S_DISP) && (r_timer == TLAST);
  assign w_price_met = (s != '0) && (r_tot >= s);
  assign w_can_pay   = (r_tot >= UNIT);

  // Coin-detect history, tracked in every state so coins outside WAIT are
  // consumed (rejected) rather than replayed later.
  always_ff @(posedge clk) begin
    if (rst) r_cq <= 1'b0;
    else     r_cq <= c;
  end

  // Sequencer FSM with credit, coin holding register and dispense timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_tot   <= '0;
      r_ahold <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_tot   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_coin) begin
            r_ahold <= a;
            r_state <= S_ADD;
          end else if (w_price_met) begin
            r_timer <= '0;
            r_state <= S_DISP;
          end else if (cancel && (r_tot != '0)) begin
            r_state <= S_CHANGE;
          end
        end
        S_ADD: begin
          r_tot   <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
          r_state <= S_WAIT;
        end
        S_DISP: begin
          // An acknowledge in the timeout cycle still counts as a sale.
          if (disp_done) begin
            r_tot   <= r_tot - s;
            r_state <= S_CHANGE;
          end else if (r_timer == TLAST) begin
            r_state <= S_CHANGE;   // credit untouched: full refund
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_CHANGE: begin
          // Residual below one change unit is forfeited.
          if (w_can_pay) begin
            r_tot <= r_tot - UNIT;
          end else begin
            r_tot   <= '0;
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign d     = (r_state == S_DISP);
  assign chg   = (r_state == S_CHANGE) && w_can_pay;
  assign busy  = (r_state == S_DISP) || (r_state == S_CHANGE);
  assign fault = w_tmo && !disp_done;
  assign tot   = r_tot;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: driver pushes expected events from a
// credit-level model, monitor observes outputs and pops/compares.
module tb_vend_sequencer;

  localparam int W  = 8;
  localparam int CU = 5;
  localparam int TO = 16;
  localparam int MAXV = (1 << W) - 1;

  localparam int K_RST  = 0;
  localparam int K_COIN = 1;
  localparam int K_TXN  = 2;

  logic         clk = 1'b0;
  logic         rst, c, cancel, disp_done;
  logic [W-1:0] a, s;
  logic         d, chg, busy, fault;
  logic [W-1:0] tot;

  vend_sequencer #(.WIDTH(W), .CHG_UNIT(CU), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .c(c), .a(a), .s(s), .cancel(cancel),
    .disp_done(disp_done), .d(d), .chg(chg), .tot(tot), .busy(busy),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int tot;
    int nchg;
    int dcyc;
    int nf;
    int lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   credit = 0;
  int   s_val = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int t, input int n, input int dc, input int f, input int l);
    exp_t e;
    e.kind = k; e.tot = t; e.nchg = n; e.dcyc = dc; e.nf = f; e.lat = l;
    q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  task automatic pop(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1; e.tot = 0; e.nchg = 0; e.dcyc = 0; e.nf = 0; e.lat = -1;
    chk("sb_nonempty", 32'(q.size() != 0), 1);
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("sb_kind", e.kind, kind);
    ok = (e.kind == kind);
  endtask

  initial begin
    bit   in_rst = 1'b0, prev_busy = 1'b0, ok;
    int   prev_tot = 0, sidx = 0, last_coin = 0, first_d = -1;
    int   cnt_d = 0, cnt_c = 0, cnt_f = 0;
    exp_t e;
    forever begin
      @(negedge clk); #1;
      sidx++;
      if (rst) begin
        in_rst = 1'b1; prev_busy = 1'b0;
        cnt_d = 0; cnt_c = 0; cnt_f = 0; first_d = -1;
        continue;
      end
      if (in_rst) begin
        in_rst = 1'b0;
        pop(K_RST, e, ok);
        if (ok) begin
          chk("rst_d", d, 0);
          chk("rst_chg", chg, 0);
          chk("rst_busy", busy, 0);
          chk("rst_fault", fault, 0);
          chk("rst_tot", tot, 0);
        end
        prev_tot = int'(tot); prev_busy = busy;
        continue;
      end
      if (d) begin
        if (cnt_d == 0) first_d = sidx;
        cnt_d++;
      end
      if (chg)   cnt_c++;
      if (fault) cnt_f++;
      if (!busy && prev_busy) begin
        pop(K_TXN, e, ok);
        if (ok) begin
          chk("txn_chg_pulses", cnt_c, e.nchg);
          chk("txn_d_cycles", cnt_d, e.dcyc);
          chk("txn_fault_pulses", cnt_f, e.nf);
          chk("txn_end_tot", tot, 0);
          if (e.lat >= 0) chk("txn_d_latency", first_d - last_coin, e.lat);
        end
        cnt_d = 0; cnt_c = 0; cnt_f = 0; first_d = -1;
      end else if (!busy && !prev_busy && int'(tot) != prev_tot) begin
        pop(K_COIN, e, ok);
        if (ok) chk("coin_tot", tot, e.tot);
        last_coin = sidx;
      end
      prev_tot = int'(tot); prev_busy = busy;
    end
  end

  // ---------------- driver helpers (all start and end at a negedge) ----------------
  task automatic set_price(input int v);
    s_val = v; s = W'(v);
    @(negedge clk);
  endtask

  task automatic coin(input int v);
    int nc;
    nc = (credit + v > MAXV) ? MAXV : credit + v;
    if (nc != credit) push(K_COIN, nc, 0, 0, 0, -1);
    credit = nc;
    c = 1'b1; a = W'(v);
    @(negedge clk);
    c = 1'b0; a = W'($urandom);
    @(negedge clk);
  endtask

  task automatic wait_d();
    for (int k = 0; k < 8 && !d; k++) @(negedge clk);
    chk("d_rise_bound", d, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && busy; k++) @(negedge clk);
    chk("idle_bound", busy, 0);
  endtask

  // Serve a pending dispense: ack lands at the end of the D-th DISP cycle.
  task automatic serve(input int dly, input bit cin_d, input bit cin_c);
    int rem, dc, f;
    if (dly < TO) begin rem = credit - s_val; dc = dly + 1; f = 0; end
    else          begin rem = credit;         dc = TO;      f = 1; end
    push(K_TXN, 0, rem / CU, dc, f, 1);
    credit = 0;
    wait_d();
    for (int i = 0; i < TO + 4; i++) begin
      disp_done = (i == dly);
      c = cin_d && (i == 0);
      a = W'($urandom);
      @(negedge clk);
      if (!d) break;
    end
    disp_done = 1'b0; c = 1'b0;
    if (cin_c) begin
      c = 1'b1; a = W'($urandom);
      @(negedge clk);
      c = 1'b0;
    end
    wait_idle();
  endtask

  task automatic cancel_txn();
    if (credit != 0) push(K_TXN, 0, credit / CU, 0, 0, -1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    credit = 0;
    wait_idle();
  endtask

  task automatic do_reset();
    push(K_RST, 0, 0, 0, 0, -1);
    c = 1'b0; cancel = 1'b0; disp_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    credit = 0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; c = 1'b0; a = '0; s = '0; cancel = 1'b0; disp_done = 1'b0;
    push(K_RST, 0, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // sale with change, stray coins during DISP and CHANGE
    set_price(60);
    coin(25); coin(25); coin(25);
    serve(3, 1'b1, 1'b1);
    // cancel refund
    coin(25); coin(7);
    cancel_txn();
    // dispense timeout: full refund
    coin(25); coin(25); coin(25);
    serve(TO + 5, 1'b0, 1'b0);
    // ack in the timeout cycle wins
    coin(25); coin(25); coin(25);
    serve(TO - 1, 1'b0, 1'b0);
    // vending disabled, saturation
    set_price(0);
    coin(200); coin(100); coin(50);
    cancel_txn();
    // reset in DISP
    set_price(60);
    coin(25); coin(25); coin(25);
    wait_d();
    repeat (2) @(negedge clk);
    do_reset();
    // reset mid-CHANGE
    coin(25); coin(7);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      int pick, dly;
      set_price(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MAXV)));
      for (int k = 0; k < 12; k++) begin
        coin(int'($urandom_range(0, 120)));
        if (s_val != 0 && credit >= s_val) break;
      end
      if (s_val != 0 && credit >= s_val) begin
        pick = int'($urandom_range(0, 3));
        dly  = (pick == 0) ? TO - 1 :
               (pick == 1) ? TO + int'($urandom_range(0, 3)) :
                             int'($urandom_range(0, TO - 2));
        serve(dly, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 5) == 0) begin
        do_reset();
      end else begin
        cancel_txn();
      end
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Top-level sequencer for the soda dispenser. It accepts coin events, accumulates a saturating credit total and compares it against the programmed price. When the price is met, it drives a dispense request/acknowledge handshake with a timeout. Afterwards it returns change, or refunds the full credit on cancel or dispense fault, as a train of single-cycle change pulses. It replaces separate total-register and control wiring with one self-contained controller that the top level connects to the coin acceptor, the dispenser mechanism and the change hopper.

## Interface
- WIDTH, 8, width of coin value, price and credit total
- CHG_UNIT, 5, value returned per change pulse; must be ≥ 1
- TIMEOUT, 16, max cycles `d` is held waiting for `disp_done`; must be ≥ 2
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- c  in  1  coin-detect level; each 0→1 edge is one coin
- a  in  WIDTH  coin value, valid in the cycle `c` first reads 1
- s  in  WIDTH  price, quasi-static; s == 0 disables vending
- cancel  in  1  refund request (level)
- disp_done  in  1  dispenser acknowledge
- d  out  1  dispense request
- chg  out  1  one-cycle pulse, one per CHG_UNIT returned
- tot  out  WIDTH  current credit total (register)
- busy  out  1  high in DISP or CHANGE
- fault  out  1  one-cycle pulse on dispense timeout

## Operation
- States: INIT, WAIT, ADD, DISP, CHANGE. Encoding is free.
- Coin edge detection: `c_q` is a register of `c`, updated in every state. A coin edge is c & ~c_q.
- INIT: tot ← 0. Next state is WAIT.
- WAIT, evaluated in priority order:
  - coin edge → ADD; `a` is captured into a holding register.
  - else s ≠ 0 and tot ≥ s → DISP; the timer is cleared.
  - else cancel and tot ≠ 0 → CHANGE (refund).
  - else stay in WAIT.
- ADD: tot ← min(tot + a_held, 2^WIDTH−1), using a saturating add with a WIDTH+1-bit sum. Next state is WAIT.
- DISP: d = 1.
  - disp_done → tot ← tot − s, then CHANGE.
  - timer == TIMEOUT−1 without done → fault = 1 for that cycle; tot is unchanged (full refund); then CHANGE.
  - otherwise the timer increments.
  - disp_done in the timeout cycle wins: no fault.
- CHANGE:
  - if tot ≥ CHG_UNIT: chg = 1 and tot ← tot − CHG_UNIT; stay in CHANGE.
  - else tot ← 0 (a residual below CHG_UNIT is forfeited); go to WAIT.
- Coin edges seen outside WAIT are dropped (coin rejected). `cancel` and `disp_done` are ignored outside WAIT and DISP respectively.
- d, chg, busy and fault are decoded from state/tot/timer registers only, with no combinational path from inputs. The exceptions are fault's dependence on `disp_done` and the fact that chg follows tot.

## Timing
- Reset: state INIT, tot = 0, timer = 0, c_q = 0. d, chg, busy and fault are all 0.
  - The first cycle after rst deasserts is INIT; WAIT follows on the next edge.
- Coin latency, with the edge seen at clock edge k in WAIT:
  - ADD after edge k.
  - tot updated at edge k+1.
  - DISP decision at edge k+2; d is high from k+2.
- d stays high until the edge at which disp_done is sampled at 1. At most it is high for TIMEOUT cycles.
- Change train: N = floor(tot/CHG_UNIT) consecutive chg cycles, then one clear cycle, then WAIT.
- rst in any state forces INIT on the next edge. d and chg drop immediately, and tot is cleared with no change paid.

## Test plan
- s=60, CHG_UNIT=5, coins 25, 25, 25 → tot 25, 50, 75; d rises 2 cycles after the third coin edge. disp_done after 3 cycles → tot 15; then 3 chg pulses (tot 10, 5, 0); back to WAIT; fault never asserted.
- s=60, coins 25 then 7 → tot 32; cancel → 6 chg pulses; tot 0; d never asserted.
- s=60, tot 75, disp_done held 0 → d high exactly 16 cycles; fault is a one-cycle pulse in the last one; then 15 chg pulses refund the full 75.
- disp_done arriving in the timeout cycle → no fault; tot 15; 3 chg pulses.
- s=0, coins 200 then 100 → tot saturates at 255; d stays 0. A coin edge during CHANGE or DISP leaves tot unchanged.
- rst asserted in DISP and separately in mid-CHANGE → d/chg are 0 after the next edge; tot = 0; INIT then WAIT.
